// File: rtl/serial_word_receiver.sv
// MSB-first serial-to-parallel word receiver with a one-word output buffer.
// Define SERIAL_RX_PARITY_EN to add a trailing even-parity bit to each frame.
module serial_word_receiver #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             Sin,
  input  logic             sin_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err
);

  localparam int CW = $clog2(WIDTH);

`ifdef SERIAL_RX_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
  // Whole word is kept so the parity bit can be checked against it
  localparam int SW = WIDTH;
`else
  typedef enum logic [0:0] {IDLE, SHIFT} state_t;
  // Last bit goes straight to the output, so one bit less needs storing
  localparam int SW = WIDTH - 1;
`endif

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [SW-1:0]    shreg_reg, shreg_next;
  logic [WIDTH-1:0] out_data_reg, out_data_next;
  logic             out_valid_reg, out_valid_next;
  logic             overrun_reg, overrun_next;
  logic             word_done;
  logic [WIDTH-1:0] word_val;
  logic             last_bit;
`ifdef SERIAL_RX_PARITY_EN
  logic             parity_err_reg, parity_err_next;
`endif

  assign last_bit = (cnt_reg == CW'(WIDTH - 1));

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    shreg_next     = shreg_reg;
    out_data_next  = out_data_reg;
    out_valid_next = out_valid_reg && !out_ready;
    overrun_next   = overrun_reg;
    word_done      = 1'b0;
    word_val       = '0;
`ifdef SERIAL_RX_PARITY_EN
    parity_err_next = parity_err_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = SHIFT;
          cnt_next   = '0;
          shreg_next = '0;
        end
      end
      SHIFT: begin
        if (start) begin
          cnt_next   = '0;
          shreg_next = '0;
        end else if (sin_valid) begin
          cnt_next = cnt_reg + CW'(1);
`ifdef SERIAL_RX_PARITY_EN
          shreg_next = {shreg_reg[WIDTH-2:0], Sin};
          if (last_bit) begin
            state_next = PARITY;
            cnt_next   = '0;
          end
`else
          word_val   = {shreg_reg, Sin};
          shreg_next = word_val[SW-1:0];
          if (last_bit) begin
            state_next = IDLE;
            cnt_next   = '0;
            word_done  = 1'b1;
          end
`endif
        end
      end
`ifdef SERIAL_RX_PARITY_EN
      PARITY: begin
        if (start) begin
          state_next = SHIFT;
          cnt_next   = '0;
          shreg_next = '0;
        end else if (sin_valid) begin
          state_next = IDLE;
          word_val   = shreg_reg;
          // Even parity: data bits plus parity bit must XOR to zero
          if (^{shreg_reg, Sin}) parity_err_next = 1'b1;
          else                   word_done       = 1'b1;
        end
      end
`endif
      default: state_next = IDLE;
    endcase

    // A buffer being consumed this cycle can be refilled without a bubble
    if (word_done) begin
      if (!out_valid_reg || out_ready) begin
        out_data_next  = word_val;
        out_valid_next = 1'b1;
      end else begin
        overrun_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      shreg_reg     <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      shreg_reg     <= shreg_next;
      out_data_reg  <= out_data_next;
      out_valid_reg <= out_valid_next;
      overrun_reg   <= overrun_next;
    end
  end

`ifdef SERIAL_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) parity_err_reg <= 1'b0;
    else       parity_err_reg <= parity_err_next;
  end
  assign parity_err = parity_err_reg;
`else
  assign parity_err = 1'b0;
`endif

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign busy      = (state_reg != IDLE);
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed bench for serial_word_receiver; covers the default build and,
// when SERIAL_RX_PARITY_EN is defined, the parity build.
module tb_serial_word_receiver;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        Sin;
  logic        sin_valid;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        overrun;
  logic        parity_err;

  int tests_run = 0;
  int tests_failed = 0;

  serial_word_receiver #(.WIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .Sin        (Sin),
    .sin_valid  (sin_valid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Pulse start, then send the top nbits of w MSB first. A full frame in the
  // parity build also carries a parity bit (even, or flipped when bad_par).
  task automatic send_frame(input logic [15:0] w, input int nbits, input bit gaps,
                            input bit rdy_last, input bit lat_chk, input bit bad_par);
    bit with_par;
    start = 1'b1;
    tick();
    start = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    with_par = (nbits == 16);
`else
    with_par = 1'b0;
`endif
    for (int i = 0; i < nbits; i++) begin
      bit last;
      last = !with_par && (i == nbits - 1);
      if (gaps) repeat ($urandom_range(0, 3)) tick();
      Sin       = w[15-i];
      sin_valid = 1'b1;
      if (last && lat_chk) check("out_valid_before_last_bit", {31'b0, out_valid}, 32'h0);
      if (last && rdy_last) out_ready = 1'b1;
      tick();
      sin_valid = 1'b0;
      if (last && rdy_last) out_ready = 1'b0;
    end
    if (with_par) begin
      if (gaps) repeat ($urandom_range(0, 3)) tick();
      Sin       = (^w) ^ bad_par;
      sin_valid = 1'b1;
      if (lat_chk) check("out_valid_before_parity_bit", {31'b0, out_valid}, 32'h0);
      if (rdy_last) out_ready = 1'b1;
      tick();
      sin_valid = 1'b0;
      if (rdy_last) out_ready = 1'b0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out_data"},   {16'b0, out_data},     32'h0);
    check({tag, "_out_valid"},  {31'b0, out_valid},    32'h0);
    check({tag, "_busy"},       {31'b0, busy},         32'h0);
    check({tag, "_overrun"},    {31'b0, overrun},      32'h0);
    check({tag, "_parity_err"}, {31'b0, parity_err},   32'h0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; Sin = 1'b0; sin_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    check_all_zero("reset");
    reset = 1'b0;

`ifdef SERIAL_RX_PARITY_EN
    send_frame(16'h0001, 16, 1'b0, 1'b0, 1'b1, 1'b0);
    check("par_good_out_valid",  {31'b0, out_valid},  32'h1);
    check("par_good_out_data",   {16'b0, out_data},   32'h0001);
    check("par_good_parity_err", {31'b0, parity_err}, 32'h0);
    check("par_good_busy",       {31'b0, busy},       32'h0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("par_consume_out_valid", {31'b0, out_valid}, 32'h0);
    send_frame(16'h0001, 16, 1'b0, 1'b0, 1'b0, 1'b1);
    check("par_bad_out_valid",  {31'b0, out_valid},  32'h0);
    check("par_bad_parity_err", {31'b0, parity_err}, 32'h1);
    check("par_bad_overrun",    {31'b0, overrun},    32'h0);
    tick();
    check("par_err_sticky", {31'b0, parity_err}, 32'h1);
`else
    // Basic frame with latency check on the last bit
    send_frame(16'hA5C3, 16, 1'b0, 1'b0, 1'b1, 1'b0);
    check("a5c3_out_data",  {16'b0, out_data},  32'hA5C3);
    check("a5c3_out_valid", {31'b0, out_valid}, 32'h1);
    check("a5c3_busy",      {31'b0, busy},      32'h0);
    check("a5c3_overrun",   {31'b0, overrun},   32'h0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("a5c3_consumed_out_valid", {31'b0, out_valid}, 32'h0);

    // Overrun: second word dropped while the first is unconsumed
    send_frame(16'h1234, 16, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(16'hBEEF, 16, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ovr_out_data",  {16'b0, out_data},  32'h1234);
    check("ovr_out_valid", {31'b0, out_valid}, 32'h1);
    check("ovr_overrun",   {31'b0, overrun},   32'h1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("ovr_consumed_out_valid", {31'b0, out_valid}, 32'h0);
    check("ovr_sticky",             {31'b0, overrun},   32'h1);
    reset = 1'b1; tick(); reset = 1'b0;
    check("ovr_cleared_by_reset", {31'b0, overrun}, 32'h0);

    // Refill in the same cycle the held word is consumed
    send_frame(16'h1111, 16, 1'b0, 1'b0, 1'b0, 1'b0);
    check("held_1111_out_data", {16'b0, out_data}, 32'h1111);
    send_frame(16'h2222, 16, 1'b0, 1'b1, 1'b0, 1'b0);
    check("refill_out_data",  {16'b0, out_data},  32'h2222);
    check("refill_out_valid", {31'b0, out_valid}, 32'h1);
    check("refill_overrun",   {31'b0, overrun},   32'h0);

    // Reset mid-frame beats start/sin_valid/out_ready in the same cycle
    send_frame(16'hFE00, 7, 1'b0, 1'b0, 1'b0, 1'b0);
    check("partial7_busy", {31'b0, busy}, 32'h1);
    reset = 1'b1; start = 1'b1; sin_valid = 1'b1; Sin = 1'b1; out_ready = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0; sin_valid = 1'b0; Sin = 1'b0; out_ready = 1'b0;
    check_all_zero("midreset");
    send_frame(16'h0001, 16, 1'b1, 1'b0, 1'b0, 1'b0);
    check("gaps_out_data",  {16'b0, out_data},  32'h0001);
    check("gaps_out_valid", {31'b0, out_valid}, 32'h1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Restart after 9 bits; only the full 0x8000 frame is delivered
    send_frame(16'hFFFF, 9, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(16'h8000, 16, 1'b0, 1'b0, 1'b1, 1'b0);
    check("restart_out_data",  {16'b0, out_data},  32'h8000);
    check("restart_out_valid", {31'b0, out_valid}, 32'h1);
    check("restart_overrun",   {31'b0, overrun},   32'h0);

    // start in the completing cycle discards the word without overrun
    send_frame(16'h4444, 15, 1'b0, 1'b0, 1'b0, 1'b0);
    Sin = 1'b0; sin_valid = 1'b1; start = 1'b1;
    tick();
    Sin = 1'b0; sin_valid = 1'b0; start = 1'b0;
    check("abort_last_out_data", {16'b0, out_data}, 32'h8000);
    check("abort_last_overrun",  {31'b0, overrun},  32'h0);
    check("abort_last_busy",     {31'b0, busy},     32'h1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("single_word_out_valid", {31'b0, out_valid}, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
